scan_bus_capture: RTL

Receiver for the multiplexed digit scan bus (`sel[2:0]`, `data[3:0]`) driven by the counter/clock display block. It samples the bus in the `clk` domain and filters out transitions. It enforces the fixed slot order 0→2→4→6 and reconstructs the four BCD digits into registered outputs. Status strobes and a lock flag let downstream logic (comparators, alarm, UART readout) consume the displayed time without sharing the display clock.

---
 rtl/scan_bus_capture.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/scan_bus_capture.sv
// Scan-bus receiver: synchronizes and debounces the multiplexed digit bus, then
// rebuilds the 4-digit BCD frame. Define SCAN_BCD_CHECK_EN to range-check digits at commit.
module scan_bus_capture #(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] sel,
  input  logic [3:0] data,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic       frame_stb,
  output logic       change_stb,
  output logic       locked,
  output logic [7:0] err_cnt
);

  localparam logic [1:0]  S_HUNT    = 2'd0;
  localparam logic [1:0]  S_GOT0    = 2'd1;
  localparam logic [1:0]  S_GOT2    = 2'd2;
  localparam logic [1:0]  S_GOT4    = 2'd3;
  localparam logic [3:0]  STABLE_C  = 4'(STABLE_CYCLES);
  localparam logic [19:0] TIMEOUT_C = 20'(TIMEOUT_CYCLES);

  function automatic logic [7:0] sat_inc_err(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [1:0] sat_inc_lock(input logic [1:0] v);
    return (v == 2'd2) ? v : v + 2'd1;
  endfunction

  function automatic logic [3:0] sat_inc_stab(input logic [3:0] v);
    return (v >= STABLE_C) ? STABLE_C : v + 4'd1;
  endfunction

`ifdef SCAN_BCD_CHECK_EN
  // Slot 4 carries the tens-of-minutes/seconds digit, so it tops out at 5.
  function automatic logic bcd_ok(input logic [15:0] v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v[11:8] <= 4'd5) && (v[15:12] <= 4'd9);
  endfunction
`endif

  logic [6:0]  sync1_q, sync1_d;
  logic [6:0]  sync2_q, sync2_d;
  logic [6:0]  prev_q, prev_d;
  logic [3:0]  stab_q, stab_d;
  logic [2:0]  last_sel_q, last_sel_d;
  logic        last_vld_q, last_vld_d;
  logic [1:0]  state_q, state_d;
  logic [19:0] tmo_q, tmo_d;
  logic [3:0]  sh0_q, sh0_d;
  logic [3:0]  sh1_q, sh1_d;
  logic [3:0]  sh2_q, sh2_d;
  logic [15:0] digits_q, digits_d;
  logic        frame_q, frame_d;
  logic        change_q, change_d;
  logic [1:0]  lock_q, lock_d;
  logic [7:0]  err_q, err_d;

  logic [2:0]  w_sel;
  logic [3:0]  w_data;
  logic        slot_acc;
  logic        tmo_hit;
  logic        err_ev;
  logic        do_commit;
  logic [2:0]  exp_sel;
  logic [15:0] commit_dig;

  // Synchronizer and stability filter
  always_comb begin
    sync1_d = {sel, data};
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    w_sel   = sync2_q[6:4];
    w_data  = sync2_q[3:0];
    stab_d  = (sync2_q == prev_q) ? sat_inc_stab(stab_q) : 4'd0;
    // A slot fires once; the same sel cannot re-fire until another sel has been accepted.
    slot_acc   = (stab_d == STABLE_C) && (!last_vld_q || (w_sel != last_sel_q));
    last_sel_d = slot_acc ? w_sel : last_sel_q;
    last_vld_d = last_vld_q | slot_acc;
  end

  // Timeout supervision between accepted slots
  always_comb begin
    tmo_hit = (state_q != S_HUNT) && (tmo_q == TIMEOUT_C) && !slot_acc;
    if ((state_q == S_HUNT) || slot_acc) begin
      tmo_d = 20'd0;
    end else if (tmo_q != TIMEOUT_C) begin
      tmo_d = tmo_q + 20'd1;
    end else begin
      tmo_d = tmo_q;
    end
  end

  // Frame sequencer and commit
  always_comb begin
    state_d    = state_q;
    sh0_d      = sh0_q;
    sh1_d      = sh1_q;
    sh2_d      = sh2_q;
    digits_d   = digits_q;
    frame_d    = 1'b0;
    change_d   = 1'b0;
    lock_d     = lock_q;
    err_d      = err_q;
    err_ev     = 1'b0;
    do_commit  = 1'b0;
    commit_dig = {w_data, sh2_q, sh1_q, sh0_q};

    case (state_q)
      S_GOT0:  exp_sel = 3'd2;
      S_GOT2:  exp_sel = 3'd4;
      S_GOT4:  exp_sel = 3'd6;
      default: exp_sel = 3'd0;
    endcase

    if (slot_acc) begin
      if (state_q == S_HUNT) begin
        if (w_sel == 3'd0) begin
          sh0_d   = w_data;
          state_d = S_GOT0;
        end
      end else if (w_sel == exp_sel) begin
        case (state_q)
          S_GOT0: begin
            sh1_d   = w_data;
            state_d = S_GOT2;
          end
          S_GOT2: begin
            sh2_d   = w_data;
            state_d = S_GOT4;
          end
          default: begin
`ifdef SCAN_BCD_CHECK_EN
            if (bcd_ok(commit_dig)) begin
              do_commit = 1'b1;
            end else begin
              err_ev = 1'b1;
            end
`else
            do_commit = 1'b1;
`endif
          end
        endcase
      end else begin
        err_ev = 1'b1;
      end
    end else if (tmo_hit) begin
      err_ev = 1'b1;
    end

    if (do_commit) begin
      digits_d = commit_dig;
      frame_d  = 1'b1;
      change_d = (commit_dig != digits_q);
      lock_d   = sat_inc_lock(lock_q);
      state_d  = S_HUNT;
    end

    if (err_ev) begin
      err_d  = sat_inc_err(err_q);
      lock_d = 2'd0;
      // An out-of-order slot 0 is a valid frame start, so keep it rather than hunt again.
      if (slot_acc && (w_sel == 3'd0)) begin
        sh0_d   = w_data;
        state_d = S_GOT0;
      end else begin
        state_d = S_HUNT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      stab_q     <= '0;
      last_sel_q <= '0;
      last_vld_q <= 1'b0;
      state_q    <= S_HUNT;
      tmo_q      <= '0;
      sh0_q      <= '0;
      sh1_q      <= '0;
      sh2_q      <= '0;
      digits_q   <= '0;
      frame_q    <= 1'b0;
      change_q   <= 1'b0;
      lock_q     <= '0;
      err_q      <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      stab_q     <= stab_d;
      last_sel_q <= last_sel_d;
      last_vld_q <= last_vld_d;
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      sh0_q      <= sh0_d;
      sh1_q      <= sh1_d;
      sh2_q      <= sh2_d;
      digits_q   <= digits_d;
      frame_q    <= frame_d;
      change_q   <= change_d;
      lock_q     <= lock_d;
      err_q      <= err_d;
    end
  end

  assign digit0     = digits_q[3:0];
  assign digit1     = digits_q[7:4];
  assign digit2     = digits_q[11:8];
  assign digit3     = digits_q[15:12];
  assign frame_stb  = frame_q;
  assign change_stb = change_q;
  assign locked     = (lock_q == 2'd2);
  assign err_cnt    = err_q;

endmodule
